// File: rtl/vdp_cartridge_slot_bridge.sv
// vdp_cartridge_slot_bridge
//   MSX cartridge-slot front end for the VDP. Synchronises the Z80 I/O strobes,
//   decodes the four VDP ports at IO_BASE..IO_BASE+3 and runs the V9938-style
//   port protocol: two-byte control latch, register writes and a 17-bit
//   auto-incrementing VRAM pointer with single-byte requests to the arbiter.
//
// Ports
//   clk, reset                  system clock, synchronous active-high reset
//   slot_iorq_n/rd_n/wr_n       asynchronous Z80 strobes
//   slot_a, slot_d_in           I/O address and write data from the bus
//   slot_d_out, slot_data_dir   read data and bus direction (1 = bridge drives)
//   oe_n                        level-shifter enable, active low
//   slot_wait, slot_intr        Z80 /WAIT request and interrupt (active high)
//   mem_init_done               SDRAM ready
//   vram_*                      single-outstanding VRAM request channel
//   reg_wr, reg_num, reg_data   register write strobe to the VDP core
//   status_data, vdp_int        status byte and frame interrupt from the core
module vdp_cartridge_slot_bridge #(
  parameter logic [7:0] IO_BASE     = 8'h88,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        slot_iorq_n,
  input  logic        slot_rd_n,
  input  logic        slot_wr_n,
  input  logic [7:0]  slot_a,
  input  logic [7:0]  slot_d_in,
  output logic [7:0]  slot_d_out,
  output logic        slot_data_dir,
  output logic        oe_n,
  output logic        slot_wait,
  output logic        slot_intr,
  input  logic        mem_init_done,
  output logic        vram_valid,
  input  logic        vram_ready,
  output logic        vram_write,
  output logic [16:0] vram_address,
  output logic [7:0]  vram_wdata,
  input  logic [7:0]  vram_rdata,
  input  logic        vram_rdata_en,
  output logic        reg_wr,
  output logic [5:0]  reg_num,
  output logic [7:0]  reg_data,
  input  logic [7:0]  status_data,
  input  logic        vdp_int
);

  logic [SYNC_STAGES-1:0] iorq_sync, rd_sync, wr_sync;
  logic        acc_on, acc_prev, acc_start, own_port, rd_now;

  // One staged command: the access captured at its start, executed once the
  // VRAM channel can take it.
  logic        cmd_v, cmd_rd;
  logic [1:0]  cmd_port;
  logic [7:0]  cmd_data;

  logic        flag;
  logic [7:0]  latch;
  logic [16:0] addr;
  logic [2:0]  r14;
  logic        ie0;
  logic [7:0]  rbuf;
  logic        rd_wait;

  logic        busy, needs_vram, exec;
  logic [16:0] addr_inc, addr_load, addr_load_inc;

  assign acc_on    = !iorq_sync[SYNC_STAGES-1] &&
                     (!rd_sync[SYNC_STAGES-1] || !wr_sync[SYNC_STAGES-1]);
  assign acc_start = acc_on && !acc_prev;
  assign own_port  = (slot_a[7:2] == IO_BASE[7:2]);
  assign rd_now    = !rd_sync[SYNC_STAGES-1];

  // A read is still busy until its data has landed in the read buffer, so a
  // following port0 read never returns stale data.
  assign busy       = vram_valid || rd_wait || !mem_init_done;
  assign needs_vram = (cmd_port == 2'd0) ||
                      ((cmd_port == 2'd1) && !cmd_rd && flag && (cmd_data[7:6] == 2'b00));
  assign exec       = cmd_v && !(needs_vram && busy);

  // The pointer advances when a request is issued; the next request cannot be
  // issued before this one is accepted, so the effect is the same as advancing
  // on accept. Natural 17-bit overflow gives the 0x1FFFF -> 0 wrap.
  assign addr_inc      = addr + 17'd1;
  assign addr_load     = {r14, cmd_data[5:0], latch};
  assign addr_load_inc = addr_load + 17'd1;

  // The transceiver stays enabled; direction alone selects who drives.
  assign oe_n = 1'b0;

  always_ff @(posedge clk) begin
    if (reset) begin
      iorq_sync     <= '1;
      rd_sync       <= '1;
      wr_sync       <= '1;
      acc_prev      <= 1'b0;
      cmd_v         <= 1'b0;
      cmd_rd        <= 1'b0;
      cmd_port      <= 2'd0;
      cmd_data      <= 8'd0;
      flag          <= 1'b0;
      latch         <= 8'd0;
      addr          <= 17'd0;
      r14           <= 3'd0;
      ie0           <= 1'b0;
      rbuf          <= 8'd0;
      rd_wait       <= 1'b0;
      slot_d_out    <= 8'd0;
      slot_data_dir <= 1'b0;
      slot_wait     <= 1'b1;
      slot_intr     <= 1'b0;
      vram_valid    <= 1'b0;
      vram_write    <= 1'b0;
      vram_address  <= 17'd0;
      vram_wdata    <= 8'd0;
      reg_wr        <= 1'b0;
      reg_num       <= 6'd0;
      reg_data      <= 8'd0;
    end else begin
      iorq_sync <= {iorq_sync[SYNC_STAGES-2:0], slot_iorq_n};
      rd_sync   <= {rd_sync[SYNC_STAGES-2:0], slot_rd_n};
      wr_sync   <= {wr_sync[SYNC_STAGES-2:0], slot_wr_n};
      acc_prev  <= acc_on;
      reg_wr    <= 1'b0;
      slot_intr <= vdp_int & ie0;
      // Holding the Z80 whenever a staged command cannot run keeps the bus
      // cycle open, so no new access can start and overwrite the stage.
      slot_wait <= !mem_init_done || (cmd_v && !exec);

      if (vram_valid && vram_ready) vram_valid <= 1'b0;
      if (vram_rdata_en) begin
        rbuf    <= vram_rdata;
        rd_wait <= 1'b0;
      end else if (vram_valid && vram_ready && !vram_write) begin
        rd_wait <= 1'b1;
      end

      if (!acc_on) begin
        slot_data_dir <= 1'b0;
        slot_d_out    <= 8'd0;
      end

      if (exec) begin
        cmd_v <= 1'b0;
        case (cmd_port)
          2'd0: begin
            flag         <= 1'b0;
            vram_valid   <= 1'b1;
            vram_write   <= !cmd_rd;
            vram_address <= addr;
            vram_wdata   <= cmd_data;
            addr         <= addr_inc;
            r14          <= addr_inc[16:14];
            if (cmd_rd) slot_d_out <= rbuf;
          end
          2'd1: begin
            if (cmd_rd) begin
              flag       <= 1'b0;
              slot_d_out <= status_data;
            end else if (!flag) begin
              latch <= cmd_data;
              flag  <= 1'b1;
            end else begin
              flag <= 1'b0;
              if (cmd_data[7]) begin
                reg_wr   <= 1'b1;
                reg_num  <= cmd_data[5:0];
                reg_data <= latch;
                if (cmd_data[5:0] == 6'd14) begin
                  r14         <= latch[2:0];
                  addr[16:14] <= latch[2:0];
                end
                if (cmd_data[5:0] == 6'd1) ie0 <= latch[5];
              end else if (cmd_data[6]) begin
                addr <= addr_load;
              end else begin
                vram_valid   <= 1'b1;
                vram_write   <= 1'b0;
                vram_address <= addr_load;
                addr         <= addr_load_inc;
                r14          <= addr_load_inc[16:14];
              end
            end
          end
          default: begin
            if (cmd_rd) slot_d_out <= 8'hFF;
          end
        endcase
      end

      if (acc_start && own_port) begin
        cmd_v         <= 1'b1;
        cmd_rd        <= rd_now;
        cmd_port      <= slot_a[1:0];
        cmd_data      <= slot_d_in;
        slot_data_dir <= rd_now;
      end
    end
  end

endmodule

// File: tb/tb_vdp_cartridge_slot_bridge.sv
module tb_vdp_cartridge_slot_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        slot_iorq_n, slot_rd_n, slot_wr_n;
  logic [7:0]  slot_a, slot_d_in, slot_d_out;
  logic        slot_data_dir, oe_n, slot_wait, slot_intr;
  logic        mem_init_done;
  logic        vram_valid, vram_ready, vram_write;
  logic [16:0] vram_address;
  logic [7:0]  vram_wdata, vram_rdata;
  logic        vram_rdata_en;
  logic        reg_wr;
  logic [5:0]  reg_num;
  logic [7:0]  reg_data, status_data;
  logic        vdp_int;

  vdp_cartridge_slot_bridge dut (
    .clk(clk), .reset(reset),
    .slot_iorq_n(slot_iorq_n), .slot_rd_n(slot_rd_n), .slot_wr_n(slot_wr_n),
    .slot_a(slot_a), .slot_d_in(slot_d_in), .slot_d_out(slot_d_out),
    .slot_data_dir(slot_data_dir), .oe_n(oe_n), .slot_wait(slot_wait),
    .slot_intr(slot_intr), .mem_init_done(mem_init_done),
    .vram_valid(vram_valid), .vram_ready(vram_ready), .vram_write(vram_write),
    .vram_address(vram_address), .vram_wdata(vram_wdata),
    .vram_rdata(vram_rdata), .vram_rdata_en(vram_rdata_en),
    .reg_wr(reg_wr), .reg_num(reg_num), .reg_data(reg_data),
    .status_data(status_data), .vdp_int(vdp_int)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // VRAM arbiter model
  int          ready_delay = 0;
  bit          rand_delay  = 1'b0;
  logic [7:0]  rdata_val   = 8'h00;
  int          dly_cnt, lim, rand_lim, rd_cd;
  logic [16:0] log_addr[$];
  logic [7:0]  log_data[$];
  logic        log_wr[$];

  initial begin
    vram_ready = 1'b0; vram_rdata_en = 1'b0; vram_rdata = 8'h00;
    dly_cnt = 0; rand_lim = 0; rd_cd = 0; lim = 0;
    forever begin
      @(negedge clk);
      vram_rdata_en = 1'b0;
      if (rd_cd > 0) begin
        rd_cd--;
        if (rd_cd == 0) begin
          vram_rdata = rdata_val;
          vram_rdata_en = 1'b1;
        end
      end
      if (vram_ready) begin
        vram_ready = 1'b0;
      end else if (vram_valid) begin
        lim = rand_delay ? rand_lim : ready_delay;
        if (dly_cnt >= lim) begin
          vram_ready = 1'b1;
          dly_cnt = 0;
          rand_lim = $urandom_range(0, 20);
          log_addr.push_back(vram_address);
          log_data.push_back(vram_wdata);
          log_wr.push_back(vram_write);
          if (!vram_write) rd_cd = 3;
        end else begin
          dly_cnt++;
        end
      end else begin
        dly_cnt = 0;
      end
    end
  end

  // Monitors
  int          reg_cnt = 0;
  logic [5:0]  last_num = 6'd0;
  logic [7:0]  last_data = 8'd0;
  int          wait_cyc = 0;
  int          unstable = 0;

  initial forever begin
    @(negedge clk);
    if (reg_wr) begin
      reg_cnt++;
      last_num = reg_num;
      last_data = reg_data;
    end
    if (slot_wait && mem_init_done && !reset) wait_cyc++;
  end

  // A pending request not accepted at this edge must still be there, unchanged.
  initial begin
    logic        pv;
    logic        pw;
    logic [16:0] pa;
    logic [7:0]  pd;
    pv = 1'b0; pw = 1'b0; pa = '0; pd = '0;
    forever begin
      @(posedge clk); #1;
      if (pv && !vram_ready && !reset)
        if (!vram_valid || vram_address != pa || vram_wdata != pd || vram_write != pw)
          unstable++;
      pv = vram_valid; pa = vram_address; pd = vram_wdata; pw = vram_write;
    end
  end

  // Z80 I/O cycle models
  task automatic io_wr(input logic [7:0] a, input logic [7:0] d);
    int n;
    @(negedge clk);
    slot_a = a; slot_d_in = d; slot_iorq_n = 1'b0; slot_wr_n = 1'b0;
    repeat (8) @(negedge clk);
    n = 0;
    while (slot_wait && n < 2000) begin @(negedge clk); n++; end
    if (n >= 2000) chk("wr_wait_timeout", {31'd0, slot_wait}, 32'd0);
    repeat (2) @(negedge clk);
    slot_iorq_n = 1'b1; slot_wr_n = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic io_rd(input logic [7:0] a, output logic [7:0] d, output logic dir);
    int n;
    @(negedge clk);
    slot_a = a; slot_iorq_n = 1'b0; slot_rd_n = 1'b0;
    repeat (8) @(negedge clk);
    n = 0;
    while (slot_wait && n < 2000) begin @(negedge clk); n++; end
    if (n >= 2000) chk("rd_wait_timeout", {31'd0, slot_wait}, 32'd0);
    repeat (2) @(negedge clk);
    d = slot_d_out; dir = slot_data_dir;
    slot_iorq_n = 1'b1; slot_rd_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rd_dir_drop", {31'd0, slot_data_dir}, 32'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_log(input string tag, input int idx, input logic [16:0] a,
                         input logic [7:0] d, input logic w);
    if (idx < log_addr.size()) begin
      chk({tag, "_addr"}, {15'd0, log_addr[idx]}, {15'd0, a});
      chk({tag, "_wr"}, {31'd0, log_wr[idx]}, {31'd0, w});
      if (w) chk({tag, "_data"}, {24'd0, log_data[idx]}, {24'd0, d});
    end else begin
      chk({tag, "_missing"}, idx, log_addr.size());
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          b, n, errs, lowc, w0;
    logic [7:0]  d;
    logic        dir;

    reset = 1'b1; slot_iorq_n = 1'b1; slot_rd_n = 1'b1; slot_wr_n = 1'b1;
    slot_a = 8'h00; slot_d_in = 8'h00; mem_init_done = 1'b0;
    status_data = 8'h00; vdp_int = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_wait", {31'd0, slot_wait}, 32'd1);
    chk("rst_dir", {31'd0, slot_data_dir}, 32'd0);
    chk("rst_oe_n", {31'd0, oe_n}, 32'd0);
    chk("rst_valid", {31'd0, vram_valid}, 32'd0);
    chk("rst_reg_wr", {31'd0, reg_wr}, 32'd0);
    chk("rst_intr", {31'd0, slot_intr}, 32'd0);
    chk("rst_dout", {24'd0, slot_d_out}, 32'd0);

    // Init: wait held for 100 clk, released within 2 clk of init done
    reset = 1'b0;
    lowc = 0;
    repeat (100) begin @(negedge clk); if (!slot_wait) lowc++; end
    chk("init_wait_held", lowc, 0);
    mem_init_done = 1'b1;
    repeat (2) @(negedge clk);
    chk("init_wait_release", {31'd0, slot_wait}, 32'd0);

    // Register write R#1 = 0x43, IE0 stays 0
    io_wr(8'h89, 8'h43);
    io_wr(8'h89, 8'h81);
    chk("reg_cnt", reg_cnt, 1);
    chk("reg_num", {26'd0, last_num}, 32'd1);
    chk("reg_data", {24'd0, last_data}, 32'h43);
    vdp_int = 1'b1;
    repeat (4) @(negedge clk);
    chk("intr_masked", {31'd0, slot_intr}, 32'd0);
    io_wr(8'h89, 8'h60);
    io_wr(8'h89, 8'h81);
    chk("intr_enabled", {31'd0, slot_intr}, 32'd1);
    vdp_int = 1'b0;
    repeat (3) @(negedge clk);
    chk("intr_follow", {31'd0, slot_intr}, 32'd0);

    // R#14 = 0, address 0x1E00, four writes
    b = log_addr.size();
    io_wr(8'h89, 8'h00); io_wr(8'h89, 8'h8E);
    io_wr(8'h89, 8'h00); io_wr(8'h89, 8'h5E);
    for (int i = 0; i < 4; i++) io_wr(8'h88, 8'h10 + 8'(i));
    chk("r14_count", log_addr.size() - b, 4);
    for (int i = 0; i < 4; i++) chk_log("r14_seq", b + i, 17'h01E00 + 17'(i), 8'h10 + 8'(i), 1'b1);

    // R#14 = 6, address 0x3FFF: carry into R#14
    b = log_addr.size();
    io_wr(8'h89, 8'h06); io_wr(8'h89, 8'h8E);
    io_wr(8'h89, 8'hFF); io_wr(8'h89, 8'h7F);
    for (int i = 0; i < 3; i++) io_wr(8'h88, 8'hC0 + 8'(i));
    chk_log("carry0", b, 17'h1BFFF, 8'hC0, 1'b1);
    chk_log("carry1", b + 1, 17'h1C000, 8'hC1, 1'b1);
    chk_log("carry2", b + 2, 17'h1C001, 8'hC2, 1'b1);

    // R#14 = 7, address 0x3FFF: wrap to 0
    b = log_addr.size();
    io_wr(8'h89, 8'h07); io_wr(8'h89, 8'h8E);
    io_wr(8'h89, 8'hFF); io_wr(8'h89, 8'h7F);
    io_wr(8'h88, 8'hE0); io_wr(8'h88, 8'hE1);
    chk_log("wrap0", b, 17'h1FFFF, 8'hE0, 1'b1);
    chk_log("wrap1", b + 1, 17'h00000, 8'hE1, 1'b1);

    // Read path: prefetch at 0x1800, then port0 reads
    b = log_addr.size();
    rdata_val = 8'hA5;
    io_wr(8'h89, 8'h00); io_wr(8'h89, 8'h18);
    repeat (20) @(negedge clk);
    chk_log("pref0", b, 17'h01800, 8'h00, 1'b0);
    rdata_val = 8'h5A;
    io_rd(8'h88, d, dir);
    chk("rd0_data", {24'd0, d}, 32'hA5);
    chk("rd0_dir", {31'd0, dir}, 32'd1);
    repeat (10) @(negedge clk);
    chk_log("pref1", b + 1, 17'h01801, 8'h00, 1'b0);
    io_rd(8'h88, d, dir);
    chk("rd1_data", {24'd0, d}, 32'h5A);
    repeat (10) @(negedge clk);
    chk_log("pref2", b + 2, 17'h01802, 8'h00, 1'b0);

    status_data = 8'h9C;
    io_rd(8'h89, d, dir);
    chk("status_data", {24'd0, d}, 32'h9C);
    chk("status_dir", {31'd0, dir}, 32'd1);
    io_rd(8'h8A, d, dir);
    chk("port2_rd", {24'd0, d}, 32'hFF);
    io_rd(8'h8C, d, dir);
    chk("foreign_dir", {31'd0, dir}, 32'd0);

    // A port1 read clears a half-written control pair
    b = log_addr.size();
    io_wr(8'h89, 8'h12);
    io_rd(8'h89, d, dir);
    io_wr(8'h89, 8'h00); io_wr(8'h89, 8'h50);
    io_wr(8'h88, 8'h77);
    chk("flagclr_count", log_addr.size() - b, 1);
    chk_log("flagclr", b, 17'h01000, 8'h77, 1'b1);

    // Sequential fill with random arbiter latency
    rand_delay = 1'b1;
    io_wr(8'h89, 8'h00); io_wr(8'h89, 8'h40);
    b = log_addr.size();
    for (int i = 0; i < 512; i++) io_wr(8'h88, 8'(i));
    repeat (30) @(negedge clk);
    n = log_addr.size() - b;
    chk("fill_count", n, 512);
    errs = 0;
    for (int i = 0; i < n && i < 512; i++)
      if (log_addr[b + i] != 17'(i) || log_data[b + i] != 8'(i) || !log_wr[b + i]) errs++;
    chk("fill_errors", errs, 0);
    rand_delay = 1'b0;

    // Backpressure: 400 clk ready latency, three back-to-back writes
    ready_delay = 400;
    io_wr(8'h89, 8'h00); io_wr(8'h89, 8'h60);
    b = log_addr.size();
    w0 = wait_cyc;
    io_wr(8'h88, 8'hAA); io_wr(8'h88, 8'hBB); io_wr(8'h88, 8'hCC);
    repeat (420) @(negedge clk);
    chk("bp_wait_long", (wait_cyc - w0) >= 700, 1);
    chk("bp_count", log_addr.size() - b, 3);
    chk_log("bp0", b, 17'h02000, 8'hAA, 1'b1);
    chk_log("bp1", b + 1, 17'h02001, 8'hBB, 1'b1);
    chk_log("bp2", b + 2, 17'h02002, 8'hCC, 1'b1);
    chk("vram_stable", unstable, 0);

    // Reset with a request pending and a half-written control pair
    io_wr(8'h88, 8'h11);
    io_wr(8'h89, 8'h33);
    chk("pend_before_rst", {31'd0, vram_valid}, 32'd1);
    reset = 1'b1; mem_init_done = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_mid_valid", {31'd0, vram_valid}, 32'd0);
    chk("rst_mid_wait", {31'd0, slot_wait}, 32'd1);
    ready_delay = 0;
    mem_init_done = 1'b1;
    repeat (3) @(negedge clk);
    b = log_addr.size();
    io_wr(8'h89, 8'h00); io_wr(8'h89, 8'h40);
    io_wr(8'h88, 8'h22);
    repeat (5) @(negedge clk);
    chk("rst_mid_count", log_addr.size() - b, 1);
    chk_log("rst_mid", b, 17'h00000, 8'h22, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
